// File: rtl/cgu_div_sched.sv
// cgu_div_sched: per-channel clock divider with shadowed divisor updates
// and wrap-aligned gating. Optional readback via CGU_DIV_SCHED_READBACK_EN.
module cgu_div_sched #(
  parameter int NCH = 4,
  parameter int DW = 8,
  parameter int DIV_RST = 4,
  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           wr_en_i,
  input  logic [AW-1:0]  wr_addr_i,
  input  logic [DW-1:0]  wr_data_i,
  input  logic [NCH-1:0] gate_req_i,
  output logic [NCH-1:0] gate_ack_o,
  output logic [NCH-1:0] busy_o,
  output logic [NCH-1:0] en_o,
  output logic [NCH-1:0] clk_o
`ifdef CGU_DIV_SCHED_READBACK_EN
  ,
  input  logic [AW-1:0]  rd_addr_i,
  output logic [DW-1:0]  rd_data_o
`endif
);

  typedef enum logic {
    RUN   = 1'b0,
    GATED = 1'b1
  } st_t;

  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] TWO  = DW'(2);
  localparam logic [DW-1:0] DRST = DW'(DIV_RST);

  logic          wr_ok;
  logic [DW-1:0] wr_val;

`ifdef CGU_DIV_SCHED_READBACK_EN
  logic [NCH-1:0][DW-1:0] d_vec;
`endif

  assign wr_ok  = wr_en_i && (int'(wr_addr_i) < NCH);
  // Divisors below 2 cannot produce a valid period.
  assign wr_val = (wr_data_i < TWO) ? TWO : wr_data_i;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    st_t           st_q;
    st_t           st_d;
    logic [DW-1:0] d_q;
    logic [DW-1:0] s_q;
    logic [DW-1:0] cnt_q;
    logic          p_q;
    logic          clk_q;
    logic          hit;
    logic          wrap;
    logic          apply;

    assign hit   = wr_ok && (wr_addr_i == AW'(i));
    assign wrap  = (st_q == RUN) && (cnt_q == d_q - ONE);
    assign apply = p_q && (wrap || (st_q == GATED));

    always_comb begin
      st_d = st_q;
      unique case (st_q)
        RUN:   if (wrap && gate_req_i[i]) st_d = GATED;
        GATED: if (!gate_req_i[i]) st_d = RUN;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        st_q  <= RUN;
        d_q   <= DRST;
        s_q   <= DRST;
        p_q   <= 1'b0;
        cnt_q <= '0;
        clk_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        clk_q <= (st_q == RUN) && (cnt_q < (d_q >> 1));
        if ((st_q == GATED) || wrap) cnt_q <= '0;
        else cnt_q <= cnt_q + ONE;
        if (apply) d_q <= s_q;
        // A write coinciding with an apply re-arms for the next boundary.
        if (hit) begin
          s_q <= wr_val;
          p_q <= 1'b1;
        end else if (apply) begin
          p_q <= 1'b0;
        end
      end
    end

    assign en_o[i]       = wrap && !rst_i;
    assign clk_o[i]      = clk_q;
    assign gate_ack_o[i] = (st_q == GATED);
    assign busy_o[i]     = p_q;
`ifdef CGU_DIV_SCHED_READBACK_EN
    assign d_vec[i]      = d_q;
`endif
  end

`ifdef CGU_DIV_SCHED_READBACK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_o <= '0;
    else if (int'(rd_addr_i) < NCH) rd_data_o <= d_vec[rd_addr_i];
    else rd_data_o <= '0;
  end
`endif

endmodule

// File: doc/cgu_div_sched.md
CGU_DIV_SCHED -- requirements
Module: cgu_div_sched

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning number of divider channels.
REQ-002 The block SHALL have parameter DW, default 8, meaning divisor width in bits.
REQ-003 The block SHALL have parameter DIV_RST, default 4, meaning divisor loaded into every channel at reset.
REQ-004 clk_i  input  1  clock.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 wr_en_i  input  1  divisor write strobe.
REQ-007 wr_addr_i  input  $clog2(NCH)  channel select for the write.
REQ-008 wr_data_i  input  DW  new divisor value.
REQ-009 gate_req_i  input  NCH  per-channel stop request, level.
REQ-010 gate_ack_o  output  NCH  per-channel stopped indication.
REQ-011 busy_o  output  NCH  per-channel divisor update pending.
REQ-012 en_o  output  NCH  per-channel one-cycle clock-enable pulse.
REQ-013 clk_o  output  NCH  per-channel divided clock, registered.

Function
REQ-014 Each channel SHALL hold an active divisor d, a shadow divisor s, a pending flag p, a counter cnt (DW bits) and a state in {RUN, GATED}.
REQ-015 A write SHALL load s of channel wr_addr_i in the next cycle and set p; writes of 0 or 1 SHALL be clamped to 2; writes with wr_addr_i >= NCH SHALL be ignored.
REQ-016 If a channel receives several writes before its update is applied, the last write SHALL win.
REQ-017 In RUN, cnt SHALL increment by 1 each cycle and wrap to 0 in the cycle after cnt == d-1 (the wrap cycle).
REQ-018 In RUN, en_o[i] SHALL be 1 exactly in the wrap cycle, otherwise 0.
REQ-019 clk_o[i] SHALL be registered, equal one cycle later to (cnt < d/2) using truncating division: period d cycles, high for floor(d/2) cycles.
REQ-020 At a wrap cycle with p set, d SHALL take s for the next period, p SHALL clear and cnt SHALL restart at 0; d SHALL never change mid-period.
REQ-021 A write landing in the wrap cycle SHALL update s and keep or set p, so it applies at the following wrap.
REQ-022 busy_o[i] SHALL equal p.
REQ-023 RUN -> GATED SHALL occur at the first wrap cycle with gate_req_i[i] = 1; that wrap cycle still pulses en_o[i].
REQ-024 In GATED, cnt SHALL be held at 0, en_o[i] = 0, clk_o[i] = 0 and gate_ack_o[i] = 1.
REQ-025 In GATED, a pending update SHALL be applied in the next cycle (d <= s, p cleared).
REQ-026 GATED -> RUN SHALL occur the cycle after gate_req_i[i] = 0; gate_ack_o[i] SHALL drop in that same cycle and cnt SHALL start from 0.
REQ-027 A deasserted gate_req_i before the wrap SHALL cancel the request with no effect.
REQ-028 Channels SHALL be fully independent; only one channel is written per cycle.

Reset
REQ-029 While rst_i = 1, every channel SHALL have d = s = DIV_RST, p = 0, cnt = 0, state RUN.
REQ-030 While rst_i = 1, en_o, clk_o, gate_ack_o and busy_o SHALL all be 0.
REQ-031 Reset asserted mid-period or mid-update SHALL discard pending writes and gate state.

Configuration
REQ-032 With macro CGU_DIV_SCHED_READBACK_EN defined, the block SHALL add input rd_addr_i ($clog2(NCH)) and output rd_data_o (DW), a registered read of the active d of the addressed channel, 1-cycle latency, reset value 0.
REQ-033 Without CGU_DIV_SCHED_READBACK_EN, these ports SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-034 Reset release, no writes -> every en_o pulses every 4 cycles, clk_o high 2 cycles of every 4.
REQ-035 Write 6 to channel 1 at cnt = 1 -> busy_o[1] = 1 until the wrap; current period stays 4, next period 6, clk_o[1] high 3 of 6.
REQ-036 Write 0 to channel 2 -> clamped to 2, en_o[2] every 2 cycles; write 5 then 7 before the wrap -> period 7 applied.
REQ-037 Raise gate_req_i[0] at cnt = 0 with d = 4 -> en_o[0] pulses at cnt = 3, then gate_ack_o[0] = 1 and clk_o[0] = 0; drop the request -> ack falls, first en_o[0] 4 cycles later.
REQ-038 Write 9 to channel 3 in its wrap cycle -> the next period stays 4, the following period is 9.
REQ-039 With CGU_DIV_SCHED_READBACK_EN: write 10 to channel 1, read back before and after the wrap -> 4, then 10.
